// File: rtl/mux2_stream_arbiter_if.sv
// Stream bundle between two sources, the arbiter and the downstream 2:1 mux.
// Handshake: a beat moves on a channel at the rising edge where valid && ready; a source holds data/last stable while valid is high and ready is low.
interface mux2_stream_arbiter_if #(
  parameter int W = 8
);
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_last;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_last;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_sel;
  logic         out_ready;

  modport slave (
    input  in0_data, in0_valid, in0_last,
    output in0_ready,
    input  in1_data, in1_valid, in1_last,
    output in1_ready,
    output out_data, out_valid, out_last, out_sel,
    input  out_ready
  );

  modport master (
    output in0_data, in0_valid, in0_last,
    input  in0_ready,
    output in1_data, in1_valid, in1_last,
    input  in1_ready,
    input  out_data, out_valid, out_last, out_sel,
    output out_ready
  );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// Two-input round-robin packet arbiter with a single output register.
// Grant is held for a whole packet; out_sel drives the downstream 2:1 mux select.
module mux2_stream_arbiter #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mux2_stream_arbiter_if.slave  bus,
  output logic [1:0]            o_dbg_state,
  output logic                  o_dbg_prio
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic         r_prio;
  logic         w_next_prio;
  logic [W-1:0] r_out_data;
  logic         r_out_valid;
  logic         r_out_last;
  logic         r_out_sel;

  logic         w_load_en;
  logic         w_grant_vld;
  logic         w_grant;
  logic         w_rdy0;
  logic         w_rdy1;
  logic         w_xfer0;
  logic         w_xfer1;
  logic         w_xfer;
  logic         w_sel;
  logic         w_last;
  logic [W-1:0] w_data;

  assign w_load_en = !r_out_valid || bus.out_ready;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = 1'b0;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    case (r_state)
      IDLE: begin
        // Contention goes to the channel that was not served last.
        if (bus.in0_valid && bus.in1_valid) begin
          w_grant_vld = 1'b1;
          w_grant     = !r_prio;
        end else if (bus.in0_valid) begin
          w_grant_vld = 1'b1;
          w_grant     = 1'b0;
        end else if (bus.in1_valid) begin
          w_grant_vld = 1'b1;
          w_grant     = 1'b1;
        end
        w_rdy0 = w_load_en && w_grant_vld && !w_grant;
        w_rdy1 = w_load_en && w_grant_vld && w_grant;
      end
      LOCK0:   w_rdy0 = w_load_en;
      LOCK1:   w_rdy1 = w_load_en;
      default: ;
    endcase
  end

  assign w_xfer0 = bus.in0_valid && w_rdy0;
  assign w_xfer1 = bus.in1_valid && w_rdy1;
  assign w_xfer  = w_xfer0 || w_xfer1;
  assign w_sel   = w_xfer1;
  assign w_last  = w_xfer1 ? bus.in1_last : bus.in0_last;
  assign w_data  = w_xfer1 ? bus.in1_data : bus.in0_data;

  always_comb begin
    w_next_state = r_state;
    w_next_prio  = r_prio;
    if (r_state != IDLE && r_state != LOCK0 && r_state != LOCK1) begin
      w_next_state = IDLE;
    end else if (w_xfer) begin
      // Only the locked channel can transfer while locked, so one rule covers IDLE and LOCKx.
      if (w_last) begin
        w_next_state = IDLE;
        w_next_prio  = w_sel;
      end else begin
        w_next_state = w_sel ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prio      <= 1'b1;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sel   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_prio  <= w_next_prio;
      if (w_xfer) begin
        r_out_data  <= w_data;
        r_out_last  <= w_last;
        r_out_sel   <= w_sel;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready && r_out_valid) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in0_ready = w_rdy0;
  assign bus.in1_ready = w_rdy1;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_sel   = r_out_sel;
  assign o_dbg_state   = r_state;
  assign o_dbg_prio    = r_prio;
endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: directed scenarios plus a randomized packet run
// checked against per-channel expected queues.
module tb_mux2_stream_arbiter;
  localparam int W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux2_stream_arbiter_if #(.W(W)) bus ();
  logic [1:0] dbg_state;
  logic       dbg_prio;

  mux2_stream_arbiter #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_prio  (dbg_prio)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W:0] exp_q0[$];
  logic [W:0] exp_q1[$];

  logic         s_x0, s_x1, s_cons;
  logic [W-1:0] s_out_data;
  logic         s_out_sel, s_out_last;

  // One clock: sample handshakes on the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    s_x0       = bus.in0_valid && bus.in0_ready;
    s_x1       = bus.in1_valid && bus.in1_ready;
    s_cons     = bus.out_valid && bus.out_ready;
    s_out_data = bus.out_data;
    s_out_sel  = bus.out_sel;
    s_out_last = bus.out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in0_data = '0; bus.in0_valid = 1'b0; bus.in0_last = 1'b0;
    bus.in1_data = '0; bus.in1_valid = 1'b0; bus.in1_last = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %0h expected 00", bus.out_data); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %0b expected 0", bus.out_last); end
    n_cmp++; if (bus.out_sel !== 1'b0) begin n_err++; $display("FAIL reset_out_sel: got %0b expected 0", bus.out_sel); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    n_cmp++; if (dbg_prio !== 1'b1) begin n_err++; $display("FAIL reset_prio: got %0b expected 1", dbg_prio); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready_novalid: got %b expected 00", {bus.in0_ready, bus.in1_ready}); end
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    #1;
    n_cmp++; if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin n_err++; $display("FAIL reset_first_contention: got %b expected 10", {bus.in0_ready, bus.in1_ready}); end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in0_valid = 1'b1; bus.in0_data = 8'h11; bus.in0_last = 1'b1;
    #1;
    n_cmp++; if (bus.in0_ready !== 1'b1) begin n_err++; $display("FAIL single_in0_ready: got %0b expected 1", bus.in0_ready); end
    step();
    bus.in0_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid: got %0b expected 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h11) begin n_err++; $display("FAIL single_out_data: got %0h expected 11", bus.out_data); end
    n_cmp++; if (bus.out_sel !== 1'b0) begin n_err++; $display("FAIL single_out_sel: got %0b expected 0", bus.out_sel); end
    n_cmp++; if (bus.out_last !== 1'b1) begin n_err++; $display("FAIL single_out_last: got %0b expected 1", bus.out_last); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_alternation();
    int a;
    int b;
    logic [W-1:0] exp_d;
    do_reset();
    a = 0; b = 0;
    bus.out_ready = 1'b1;
    bus.in0_valid = 1'b1; bus.in0_last = 1'b1; bus.in0_data = 8'hA0;
    bus.in1_valid = 1'b1; bus.in1_last = 1'b1; bus.in1_data = 8'hB0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (s_x0) a++;
      if (s_x1) b++;
      bus.in0_data = W'(8'hA0 + a);
      bus.in1_data = W'(8'hB0 + b);
      exp_d = (k % 2 == 1) ? W'(8'hB0 + k / 2) : W'(8'hA0 + k / 2);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL alt_valid[%0d]: got %0b expected 1", k, bus.out_valid); end
      n_cmp++; if (bus.out_sel !== 1'(k % 2)) begin n_err++; $display("FAIL alt_sel[%0d]: got %0b expected %0d", k, bus.out_sel, k % 2); end
      n_cmp++; if (bus.out_data !== exp_d) begin n_err++; $display("FAIL alt_data[%0d]: got %0h expected %0h", k, bus.out_data, exp_d); end
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic         v[4];
    logic [W-1:0] d[4];
    logic         l[4];
    v = '{1'b1, 1'b1, 1'b0, 1'b1};
    d = '{8'h01, 8'h02, 8'h00, 8'h03};
    l = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus.out_ready = 1'b1;
    bus.in1_valid = 1'b1; bus.in1_data = 8'hC1; bus.in1_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in0_valid = v[k]; bus.in0_data = d[k]; bus.in0_last = l[k];
      #1;
      n_cmp++; if (bus.in1_ready !== 1'b0) begin n_err++; $display("FAIL lock_in1_ready[%0d]: got %0b expected 0", k, bus.in1_ready); end
      step();
      if (v[k]) begin
        n_cmp++; if ({bus.out_sel, bus.out_data} !== {1'b0, d[k]}) begin n_err++; $display("FAIL lock_out[%0d]: got sel %0b data %0h expected sel 0 data %0h", k, bus.out_sel, bus.out_data, d[k]); end
      end
    end
    bus.in0_valid = 1'b0;
    #1;
    n_cmp++; if (bus.in1_ready !== 1'b1) begin n_err++; $display("FAIL lock_release_ready: got %0b expected 1", bus.in1_ready); end
    step();
    n_cmp++; if ({bus.out_sel, bus.out_data} !== {1'b1, 8'hC1}) begin n_err++; $display("FAIL lock_release_out: got sel %0b data %0h expected sel 1 data c1", bus.out_sel, bus.out_data); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic         rd[12];
    logic [W-1:0] exp_seq[8];
    int a;
    int b;
    int c;
    rd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) exp_seq[i] = (i % 2 == 1) ? W'(8'hB0 + i / 2) : W'(8'hA0 + i / 2);
    do_reset();
    a = 0; b = 0; c = 0;
    bus.in0_valid = 1'b1; bus.in0_last = 1'b1; bus.in0_data = 8'hA0;
    bus.in1_valid = 1'b1; bus.in1_last = 1'b1; bus.in1_data = 8'hB0;
    for (int k = 0; k < 12; k++) begin
      bus.out_ready = rd[k];
      #1;
      if (!rd[k]) begin
        n_cmp++; if ({bus.out_valid, bus.in0_ready, bus.in1_ready} !== 3'b100) begin n_err++; $display("FAIL bp_stall[%0d]: got valid/rdy0/rdy1 %b expected 100", k, {bus.out_valid, bus.in0_ready, bus.in1_ready}); end
        n_cmp++; if (bus.out_data !== exp_seq[c]) begin n_err++; $display("FAIL bp_hold[%0d]: got %0h expected %0h", k, bus.out_data, exp_seq[c]); end
      end
      step();
      if (s_cons) begin
        n_cmp++; if (s_out_data !== exp_seq[c]) begin n_err++; $display("FAIL bp_seq[%0d]: got %0h expected %0h", c, s_out_data, exp_seq[c]); end
        c++;
      end
      if (s_x0) a++;
      if (s_x1) b++;
      bus.in0_data = W'(8'hA0 + a);
      bus.in1_data = W'(8'hB0 + b);
    end
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      if (s_cons && c < 8) begin
        n_cmp++; if (s_out_data !== exp_seq[c]) begin n_err++; $display("FAIL bp_seq[%0d]: got %0h expected %0h", c, s_out_data, exp_seq[c]); end
      end
      if (s_cons) c++;
    end
    n_cmp++; if (c !== 8 || a + b !== 8) begin n_err++; $display("FAIL bp_count: got consumed %0d accepted %0d expected 8 and 8", c, a + b); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.in1_valid = 1'b1; bus.in1_data = W'(8'hD1 + k); bus.in1_last = 1'b0;
      step();
    end
    bus.in1_data = 8'hD3;
    bus.in0_valid = 1'b1; bus.in0_data = 8'hE0; bus.in0_last = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %0b expected 0", bus.out_valid); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    #1;
    n_cmp++; if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin n_err++; $display("FAIL rstmid_grant: got %b expected 10", {bus.in0_ready, bus.in1_ready}); end
    step();
    n_cmp++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 1'b0, 8'hE0}) begin n_err++; $display("FAIL rstmid_out: got valid %0b sel %0b data %0h expected 1 0 e0", bus.out_valid, bus.out_sel, bus.out_data); end
    idle_inputs();
  endtask

  task automatic test_random();
    int           cyc;
    int           pk_left[2];
    int           rem[2];
    logic [6:0]   cnt[2];
    logic         have[2];
    logic [W-1:0] dat[2];
    logic         lst[2];
    logic         open_pkt;
    logic         open_sel;
    logic [W:0]   exp_b;
    logic         ok;
    do_reset();
    exp_q0.delete();
    exp_q1.delete();
    for (int ch = 0; ch < 2; ch++) begin
      pk_left[ch] = 1000; rem[ch] = 0; cnt[ch] = '0; have[ch] = 1'b0; dat[ch] = '0; lst[ch] = 1'b0;
    end
    open_pkt = 1'b0; open_sel = 1'b0; cyc = 0;
    while (cyc < 40000 && !(pk_left[0] == 0 && pk_left[1] == 0 && !have[0] && !have[1] &&
                            exp_q0.size() == 0 && exp_q1.size() == 0)) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (!have[ch] && pk_left[ch] > 0 && $urandom_range(0, 99) < 70) begin
          if (rem[ch] == 0) rem[ch] = $urandom_range(1, 5);
          dat[ch] = {(ch == 1), cnt[ch]};
          cnt[ch] = cnt[ch] + 7'd1;
          lst[ch] = (rem[ch] == 1);
          rem[ch] = rem[ch] - 1;
          if (lst[ch]) pk_left[ch] = pk_left[ch] - 1;
          have[ch] = 1'b1;
          if (ch == 0) exp_q0.push_back({lst[ch], dat[ch]});
          else         exp_q1.push_back({lst[ch], dat[ch]});
        end
      end
      bus.in0_valid = have[0]; bus.in0_data = dat[0]; bus.in0_last = lst[0];
      bus.in1_valid = have[1]; bus.in1_data = dat[1]; bus.in1_last = lst[1];
      bus.out_ready = ($urandom_range(0, 99) < 75);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        n_cmp++; if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin n_err++; $display("FAIL rnd_backpressure cyc %0d: got %b expected 00", cyc, {bus.in0_ready, bus.in1_ready}); end
      end
      step();
      cyc++;
      n_cmp++; if (s_x0 && s_x1) begin n_err++; $display("FAIL rnd_dual_xfer cyc %0d: got both channels expected at most one", cyc); end
      if (s_x0) have[0] = 1'b0;
      if (s_x1) have[1] = 1'b1 ^ 1'b1;
      if (s_cons) begin
        ok = s_out_sel ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
        exp_b = '0;
        if (ok) exp_b = s_out_sel ? exp_q1.pop_front() : exp_q0.pop_front();
        n_cmp++; if (!ok || {s_out_last, s_out_data} !== exp_b) begin n_err++; $display("FAIL rnd_beat cyc %0d ch %0b: got %0h expected %0h (queued %0b)", cyc, s_out_sel, {s_out_last, s_out_data}, exp_b, ok); end
        n_cmp++; if (open_pkt && s_out_sel !== open_sel) begin n_err++; $display("FAIL rnd_interleave cyc %0d: got ch %0b expected ch %0b", cyc, s_out_sel, open_sel); end
        open_pkt = !s_out_last;
        open_sel = s_out_sel;
      end
    end
    n_cmp++; if (cyc >= 40000) begin n_err++; $display("FAIL rnd_timeout: got %0d/%0d beats left expected 0/0", exp_q0.size(), exp_q1.size()); end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_alternation();
    test_lock();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux2_stream_arbiter.md
# mux2_stream_arbiter

Two-input round-robin stream arbiter feeding the 2:1 selection stage. It accepts beats from two valid/ready source channels and grants one channel at a time, holding the grant for a whole packet (until `last`). It forwards the selected beat through a single output register together with the select bit (`out_sel`) that the downstream 2:1 multiplexer uses as its selector. One beat per cycle sustained.

## Interface
- `W`, 8, data width of each channel's beat
- `clk`  input  1  rising-edge clock; single clock domain
- `rst`  input  1  synchronous, active-high reset
- `in0_data`  input  W  channel 0 beat data
- `in0_valid`  input  1  channel 0 beat present
- `in0_last`  input  1  channel 0 beat is final beat of packet
- `in0_ready`  output  1  channel 0 beat accepted this cycle (when valid)
- `in1_data`, `in1_valid`, `in1_last`, `in1_ready`: same as channel 0, for channel 1
- `out_data`  output  W  registered forwarded beat
- `out_valid`  output  1  output register holds a beat
- `out_last`  output  1  registered last flag of forwarded beat
- `out_sel`  output  1  registered source index of forwarded beat (0 or 1); selector for downstream mux
- `out_ready`  input  1  downstream accepts output beat

## Operation
- `load_en = !out_valid || out_ready`. The output register loads only when `load_en` is 1.
- Channel x transfer: `inx_valid && inx_ready`. At most one channel transfers per cycle.
- State machine states: IDLE, LOCK0, LOCK1. Pointer `prio` holds the last-served channel.
- IDLE grant:
  - Only one valid: that channel.
  - Both valid: channel `!prio`.
  - None valid: no grant.
- IDLE: `inx_ready = load_en && grant==x`. Readies depend combinationally on valids (no combinational path from ready to valid in sources required).
- LOCKx: `inx_ready = load_en`; other channel ready = 0 regardless of its valid.
- Transfer in IDLE:
  - `last=1`: stay IDLE and set `prio=x`.
  - `last=0`: go to LOCKx.
- Transfer in LOCKx:
  - `last=1`: go to IDLE and set `prio=x`.
  - `last=0`: stay in LOCKx.
- On transfer from x: `out_data<=inx_data`, `out_last<=inx_last`, `out_sel<=x`, `out_valid<=1`.
- No transfer but `out_ready && out_valid`: `out_valid<=0`. Data, last and sel hold their values.
- Single-beat packets (`last=1` on the first beat) never lock. Both valid continuously with single-beat packets gives strict alternation 0,1,0,1.
- Source beat held without ready must stay stable (AXI-stream rules). The block does not check this.

## Timing
- Reset (sync, dominates all else):
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`.
  - State IDLE, `prio=1`, so channel 0 wins the first contention.
  - `in0_ready`/`in1_ready` follow from reset state: IDLE with `out_valid=0`, so ready = grant.
- Reset mid-packet: lock is dropped and any held output beat is discarded. No partial-packet recovery.
- Latency: input transfer at edge N → `out_valid=1` with that beat visible after edge N.
- Throughput: `out_ready` held 1 → one beat per cycle, no bubbles.
- Backpressure: `out_ready=0` with `out_valid=1` → both readies 0; the output register holds.
- Simultaneous output drain and new transfer in the same cycle: the register is overwritten with the new beat and `out_valid` stays 1.
- Locked channel deasserts valid mid-packet: the lock is held and the other channel stalls until the locked channel's `last` beat transfers.

## Test plan
- Reset, then `in0_valid=1`, `in0_data=0x11`, `last=1`, `out_ready=1` → `in0_ready=1` same cycle; next cycle `out_data=0x11`, `out_sel=0`, `out_last=1`, `out_valid=1`.
- Both channels valid with single-beat packets (ch0 0xA0.., ch1 0xB0..) and `out_ready=1` for 6 cycles → output sel sequence 0,1,0,1,0,1, one beat/cycle.
- Ch0 sends 3-beat packet (0x01,0x02,0x03 last) while ch1 is valid throughout → `in1_ready=0` until after 0x03 transfers; then ch1 beat appears with `out_sel=1`.
- `out_ready=0` for 4 cycles with both valid → `out_valid=1` and `out_data` frozen, both readies 0; on `out_ready=1` resume with no loss or duplication (scoreboard by sequence).
- Assert `rst` during LOCK1 after 2 of 4 beats → next cycle `out_valid=0`, state IDLE, and with both valid the next grant goes to channel 0.
- Randomised valid/out_ready toggling, 1000 packets of 1-5 beats per channel → per-channel order preserved, packets never interleaved, no beat loss.
